// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - CPU-side read/write bus of the data memory responder
interface data_memory_responder_if;
    logic        ReadMemEN;
    logic [31:0] ReadMemoryAdr;
    logic [31:0] ReadMemory;
    logic        ReadValid;
    logic        WriteMemEN;
    logic [31:0] WriteMemoryAdr;
    logic [31:0] WriteMemory;
    logic        Busy;
    logic        AddrError;
    logic [7:0]  ErrCount;

    modport master (
        output ReadMemEN, ReadMemoryAdr, WriteMemEN, WriteMemoryAdr, WriteMemory,
        input  ReadMemory, ReadValid, Busy, AddrError, ErrCount
    );

    modport slave (
        input  ReadMemEN, ReadMemoryAdr, WriteMemEN, WriteMemoryAdr, WriteMemory,
        output ReadMemory, ReadValid, Busy, AddrError, ErrCount
    );
endinterface

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - word memory with zero-wait writes, fixed-latency reads and address checking
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_responder_if.slave      bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

    typedef enum logic {IDLE, WAIT} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW-1:0]  rd_idx_q, rd_idx_d;
    logic [31:0]    rdata_q;
    logic           rvalid_q, rvalid_d;
    logic           busy_q, busy_d;
    logic           aerr_q, aerr_d;
    logic [7:0]     ecnt_q, ecnt_d;

    logic           rd_legal, wr_legal;
    logic           rd_err, wr_err;
    logic           wr_en, complete;
    logic [AW-1:0]  wr_idx;

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a} < LIMIT);
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, c} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign rd_legal = is_legal(bus.ReadMemoryAdr);
    assign wr_legal = is_legal(bus.WriteMemoryAdr);
    assign wr_idx   = bus.WriteMemoryAdr[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        rvalid_d = 1'b0;
        busy_d   = busy_q;
        aerr_d   = 1'b0;
        ecnt_d   = ecnt_q;
        rd_err   = 1'b0;
        wr_err   = 1'b0;
        wr_en    = 1'b0;
        complete = 1'b0;
        case (state_q)
            IDLE: begin
                rd_err = bus.ReadMemEN  && !rd_legal;
                wr_err = bus.WriteMemEN && !wr_legal;
                wr_en  = bus.WriteMemEN && wr_legal;
                if (bus.ReadMemEN && rd_legal) begin
                    state_d  = WAIT;
                    cnt_d    = 4'(WAIT_CYCLES);
                    rd_idx_d = bus.ReadMemoryAdr[AW+1:2];
                    busy_d   = 1'b1;
                end
                aerr_d = rd_err || wr_err;
                ecnt_d = sat_add(ecnt_q, {1'b0, rd_err} + {1'b0, wr_err});
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a zero counter can never strand the FSM in WAIT
                if (cnt_q <= 4'd1) begin
                    complete = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    cnt_d    = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rd_idx_q <= '0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            aerr_q   <= 1'b0;
            ecnt_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            aerr_q   <= aerr_d;
            ecnt_q   <= ecnt_d;
            if (complete) begin
                rdata_q <= mem[rd_idx_q];
            end
        end
    end

    // Reads sample the array only at completion, so a same-edge write is already visible
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_idx] <= bus.WriteMemory;
        end
    end

    assign bus.ReadMemory = rdata_q;
    assign bus.ReadValid  = rvalid_q;
    assign bus.Busy       = busy_q;
    assign bus.AddrError  = aerr_q;
    assign bus.ErrCount   = ecnt_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - scoreboard bench for data_memory_responder
module tb_data_memory_responder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] exp_q [$];

    data_memory_responder_if bus();

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ReadMemEN  = 1'b0;
        bus.WriteMemEN = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.WriteMemEN     = 1'b1;
        bus.WriteMemoryAdr = a;
        bus.WriteMemory    = d;
        tick();
        bus.WriteMemEN = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.ReadValid && n < 20) begin
            tick();
            n++;
        end
        chk("read_complete", 32'(bus.ReadValid), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] e);
        bus.ReadMemEN     = 1'b1;
        bus.ReadMemoryAdr = a;
        exp_q.push_back(e);
        tick();
        bus.ReadMemEN = 1'b0;
        chk("read_accept_busy", 32'(bus.Busy), 32'd1);
        wait_valid();
    endtask

    // Monitor: every ReadValid pulse must match the oldest outstanding expected read
    always @(negedge clk) begin
        if (bus.ReadValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_readvalid: got data %h with no read outstanding", bus.ReadMemory);
            end else begin
                chk("read_data", bus.ReadMemory, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        errors = 0;
        checks = 0;
        reset = 1'b0;
        bus.ReadMemEN = 1'b0;
        bus.WriteMemEN = 1'b0;
        bus.ReadMemoryAdr = 32'd0;
        bus.WriteMemoryAdr = 32'd0;
        bus.WriteMemory = 32'd0;
        repeat (2) tick();
        chk("rst_busy",   32'(bus.Busy), 32'd0);
        chk("rst_rvalid", 32'(bus.ReadValid), 32'd0);
        chk("rst_aerr",   32'(bus.AddrError), 32'd0);
        chk("rst_ecnt",   32'(bus.ErrCount), 32'd0);
        chk("rst_rdata",  bus.ReadMemory, 32'd0);

        // Write presented on the very first edge with reset released
        reset = 1'b1;
        wr(32'h10, 32'h0000_00A5);
        wr(32'h00, 32'h1111_1111);
        wr(32'h30, 32'h1234_5678);

        // Exact read latency with WAIT_CYCLES=2
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h10;
        exp_q.push_back(32'h0000_00A5);
        tick();
        bus.ReadMemEN = 1'b0;
        chk("lat_busy_n",   32'(bus.Busy), 32'd1);
        chk("lat_rv_n",     32'(bus.ReadValid), 32'd0);
        tick();
        chk("lat_busy_n1",  32'(bus.Busy), 32'd1);
        chk("lat_rv_n1",    32'(bus.ReadValid), 32'd0);
        tick();
        chk("lat_busy_n2",  32'(bus.Busy), 32'd0);
        chk("lat_rv_n2",    32'(bus.ReadValid), 32'd1);
        chk("lat_data_n2",  bus.ReadMemory, 32'h0000_00A5);
        tick();
        chk("rv_one_cycle", 32'(bus.ReadValid), 32'd0);
        chk("rdata_hold",   bus.ReadMemory, 32'h0000_00A5);

        // Same-edge write and read at one index returns the new value
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h20;
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h20;
        bus.WriteMemory = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        idle();
        wait_valid();

        // Both illegal: one AddrError pulse, two counts
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h13;
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h1000;
        bus.WriteMemory = 32'hBAD0_BAD0;
        tick();
        idle();
        chk("both_ill_aerr", 32'(bus.AddrError), 32'd1);
        chk("both_ill_ecnt", 32'(bus.ErrCount), 32'd2);
        chk("both_ill_busy", 32'(bus.Busy), 32'd0);
        tick();
        chk("aerr_pulse",    32'(bus.AddrError), 32'd0);
        do_read(32'h00, 32'h1111_1111);

        // Legal read with misaligned write: read proceeds, write flagged
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h10;
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h02;
        bus.WriteMemory = 32'h0000_0055;
        exp_q.push_back(32'h0000_00A5);
        tick();
        idle();
        chk("mix_aerr", 32'(bus.AddrError), 32'd1);
        chk("mix_ecnt", 32'(bus.ErrCount), 32'd3);
        chk("mix_busy", 32'(bus.Busy), 32'd1);
        wait_valid();
        do_read(32'h00, 32'h1111_1111);

        // Write and address change while Busy are ignored
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h30;
        exp_q.push_back(32'h1234_5678);
        tick();
        bus.ReadMemEN = 1'b0;
        bus.ReadMemoryAdr = 32'h10;
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h30;
        bus.WriteMemory = 32'hCAFE_F00D;
        tick();
        idle();
        wait_valid();
        chk("busy_no_err", 32'(bus.ErrCount), 32'd3);
        wr(32'h30, 32'hCAFE_F00D);
        do_read(32'h30, 32'hCAFE_F00D);

        // Back-to-back reads accepted on the ReadValid edge
        do_read(32'h10, 32'h0000_00A5);
        do_read(32'h20, 32'hDEAD_BEEF);
        tick();

        // Reset mid-WAIT abandons the read
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h10;
        tick();
        bus.ReadMemEN = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_busy",   32'(bus.Busy), 32'd0);
        chk("mid_rst_rvalid", 32'(bus.ReadValid), 32'd0);
        chk("mid_rst_aerr",   32'(bus.AddrError), 32'd0);
        chk("mid_rst_ecnt",   32'(bus.ErrCount), 32'd0);
        chk("mid_rst_rdata",  bus.ReadMemory, 32'd0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (bus.ReadValid) seen = 1'b1;
        end
        chk("no_rv_after_rst", 32'(seen), 32'd0);
        do_read(32'h10, 32'h0000_00A5);

        // ErrCount saturation
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h1000;
        repeat (254) tick();
        chk("ecnt_254", 32'(bus.ErrCount), 32'd254);
        repeat (46) tick();
        idle();
        chk("ecnt_sat", 32'(bus.ErrCount), 32'd255);
        bus.ReadMemEN = 1'b1;
        bus.ReadMemoryAdr = 32'h0000_0FFC + 32'd4;
        bus.WriteMemEN = 1'b1;
        bus.WriteMemoryAdr = 32'h1;
        tick();
        idle();
        chk("sat_both_aerr", 32'(bus.AddrError), 32'd1);
        chk("sat_both_ecnt", 32'(bus.ErrCount), 32'd255);
        do_read(32'h0000_0FFC - 32'h0000_0FCC, 32'hCAFE_F00D);

        tick();
        chk("pending_reads", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
